// File: rtl/input_transform_unit_if.sv
// input_transform_unit_if: start/tile/result/status bundle between a tile source and the Winograd input transform
interface input_transform_unit_if #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 16
);
   logic                             start;
   logic [0:5][0:5][DATA_W-1:0]      matrix_in;
   logic [0:5][0:5][OUT_W-1:0]       matrix_out;
   logic                             busy;
   logic                             transform_done;
   modport master (output start, matrix_in, input matrix_out, busy, transform_done);
   modport slave  (input start, matrix_in, output matrix_out, busy, transform_done);
endinterface

// File: rtl/input_transform_unit.sv
// input_transform_unit: Winograd F(4x4,3x3) input transform V = B^T*d*B, row pass then column pass, one vector per cycle.
// Optional macro INPUT_TRANSFORM_SAT_EN: saturate V elements to OUT_W instead of wrapping.
module input_transform_unit #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   input_transform_unit_if.slave bus
);
   localparam int            ACC_W  = DATA_W + 8;
   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_ROW  = 2'd1;
   localparam logic [1:0]    S_COL  = 2'd2;
   localparam logic [1:0]    S_DONE = 2'd3;
   localparam logic signed [ACC_W-1:0] V_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] V_MIN = -V_MAX - 1;

   logic [1:0]                     state_q, state_d;
   logic [2:0]                     cnt_q, cnt_d;
   logic [0:5][0:5][DATA_W-1:0]    d_q, d_d;
   logic [0:5][0:5][DATA_W+3:0]    t_q, t_d;
   logic [0:5][0:5][OUT_W-1:0]     out_q, out_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic [0:5][ACC_W-1:0]          vec;

   // One row of B^T applied to a 6-vector; coefficients realised as shifts and adds.
   function automatic logic signed [ACC_W-1:0] bt_dot(input logic [2:0] r, input logic [0:5][ACC_W-1:0] x);
      logic signed [ACC_W-1:0] x0, x1, x2, x3, x4, x5;
      x0 = $signed(x[0]);
      x1 = $signed(x[1]);
      x2 = $signed(x[2]);
      x3 = $signed(x[3]);
      x4 = $signed(x[4]);
      x5 = $signed(x[5]);
      case (r)
         3'd0:    return (x0 <<< 2) - (x2 <<< 2) - x2 + x4;
         3'd1:    return -(x1 <<< 2) - (x2 <<< 2) + x3 + x4;
         3'd2:    return (x1 <<< 2) - (x2 <<< 2) - x3 + x4;
         3'd3:    return -(x1 <<< 1) - x2 + (x3 <<< 1) + x4;
         3'd4:    return (x1 <<< 1) - x2 - (x3 <<< 1) + x4;
         default: return (x1 <<< 2) - (x3 <<< 2) - x3 + x5;
      endcase
   endfunction

   // Narrow a full-precision V element to the output width.
   function automatic logic [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef INPUT_TRANSFORM_SAT_EN
      return v > V_MAX ? OUT_W'(V_MAX) : v < V_MIN ? OUT_W'(V_MIN) : OUT_W'(v);
`else
      return OUT_W'(v);
`endif
   endfunction

   // Sequencing: capture the tile, write one T row per ROW cycle, one V column per COL cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      t_d     = t_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      vec     = '0;
      if (state_q == S_IDLE) begin
         if (bus.start) begin
            d_d     = bus.matrix_in;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            state_d = S_ROW;
         end
      end else if (state_q == S_ROW) begin
         for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 6; k++) vec[k] = ACC_W'($signed(d_q[k][j]));
            t_d[cnt_q][j] = (DATA_W + 4)'(bt_dot(cnt_q, vec));
         end
         cnt_d   = cnt_q == 3'd5 ? 3'd0 : cnt_q + 3'd1;
         state_d = cnt_q == 3'd5 ? S_COL : S_ROW;
      end else if (state_q == S_COL) begin
         for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 6; k++) vec[k] = ACC_W'($signed(t_q[i][k]));
            out_d[i][cnt_q] = reduce(bt_dot(cnt_q, vec));
         end
         cnt_d   = cnt_q == 3'd5 ? 3'd0 : cnt_q + 3'd1;
         state_d = cnt_q == 3'd5 ? S_DONE : S_COL;
         done_d  = cnt_q == 3'd5;
      end else begin
         busy_d  = 1'b0;
         state_d = S_IDLE;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         d_q     <= '0;
         t_q     <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         t_q     <= t_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.matrix_out     = out_q;
   assign bus.busy           = busy_q;
   assign bus.transform_done = done_q;
endmodule

// File: tb/tb_input_transform_unit.sv
// tb_input_transform_unit: directed and random checks of the Winograd input transform against a matrix-product model.
module tb_input_transform_unit;
   typedef logic [0:5][0:5][15:0] mat_t;
   localparam int BT[6][6] = '{
      '{4, 0, -5, 0, 1, 0},
      '{0, -4, -4, 1, 1, 0},
      '{0, 4, -4, -1, 1, 0},
      '{0, -2, -1, 2, 1, 0},
      '{0, 2, -1, -2, 1, 0},
      '{0, 4, 0, -5, 0, 1}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   mat_t sb[$];
   mat_t imp, ones, big;

   input_transform_unit_if #(.DATA_W(16), .OUT_W(16)) bus ();
   input_transform_unit #(.DATA_W(16), .OUT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic mat_t golden(input mat_t d);
      longint t[6][6];
      longint v;
      mat_t   r;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            t[i][j] = 0;
            for (int k = 0; k < 6; k++) t[i][j] += BT[i][k] * longint'($signed(d[k][j]));
         end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            v = 0;
            for (int k = 0; k < 6; k++) v += t[i][k] * BT[j][k];
`ifdef INPUT_TRANSFORM_SAT_EN
            r[i][j] = v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
`else
            r[i][j] = 16'(v);
`endif
         end
      return r;
   endfunction

   function automatic mat_t rnd_tile();
      mat_t r;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) r[i][j] = 16'(int'($urandom_range(0, 1023)) - 512);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_tile(input mat_t d, input bit pulse);
      int   n;
      mat_t exp;
      bus.matrix_in = d;
      bus.start     = 1'b1;
      sb.push_back(golden(d));
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.matrix_in = rnd_tile();
      n = 0;
      while (bus.transform_done !== 1'b1 && n < 30) begin
         bus.start = pulse && (n == 2 || n == 7);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 12);
      chk("busy_at_done", bus.busy, 1'b1);
      exp = sb.pop_front();
      chk("matrix_out", bus.matrix_out, exp);
      bus.start = pulse;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_clear", bus.transform_done, 1'b0);
      chk("busy_clear", bus.busy, 1'b0);
      if (pulse) begin
         @(posedge clk); #1;
         chk("start_in_done_ignored", bus.busy, 1'b0);
      end
   endtask

   initial begin
      int done_seen;
      bus.start     = 1'b0;
      bus.matrix_in = '0;
      imp  = '0;
      imp[2][2] = 16'd1;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            ones[i][j] = 16'd1;
            big[i][j]  = 16'd32767;
         end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", bus.matrix_out, '0);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_done", bus.transform_done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      do_tile(imp, 1'b0);
      chk("t1_v00", bus.matrix_out[0][0], 16'd25);
      chk("t1_v01", bus.matrix_out[0][1], 16'd20);
      chk("t1_v33", bus.matrix_out[3][3], 16'd1);
      chk("t1_row5", bus.matrix_out[5], '0);
      for (int i = 0; i < 6; i++) chk("t1_col5", bus.matrix_out[i][5], 16'd0);

      do_tile(ones, 1'b0);
      chk("t2_v11", bus.matrix_out[1][1], 16'd36);

      do_tile(big, 1'b0);
`ifdef INPUT_TRANSFORM_SAT_EN
      chk("t3_v11", bus.matrix_out[1][1], 16'h7fff);
`else
      chk("t3_v11", bus.matrix_out[1][1], 16'hffdc);
`endif
      chk("t3_v00", bus.matrix_out[0][0], 16'd0);

      do_tile(ones, 1'b1);

      bus.matrix_in = imp;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_out_zero", bus.matrix_out, '0);
      chk("t5_busy_zero", bus.busy, 1'b0);
      chk("t5_done_zero", bus.transform_done, 1'b0);
      done_seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus.transform_done === 1'b1) done_seen++;
      end
      chk("t5_no_done", done_seen, 0);
      rst_n = 1'b1;
      @(negedge clk);
      do_tile(imp, 1'b0);
      chk("t5_v00", bus.matrix_out[0][0], 16'd25);

      for (int t = 0; t < 200; t++) do_tile(rnd_tile(), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
